// File: rtl/beat_seq_pkg.sv
// Shared types and constants for the beat memory record/playback address sequencer.
package beat_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_PLAY,
        S_DONE
    } state_t;

    localparam logic [6:0] IDLE_CODE_DEFAULT = 7'd32;

endpackage

// File: rtl/beat_tick_divider.sv
// Playback step timer: pulses tick for one cycle every TICK_DIV enabled cycles.
module beat_tick_divider #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = enable && !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/beat_address_sequencer.sv
// Unified record/playback address generator for the beat memory.
// Define BEAT_SEQ_LOOP_EN to make playback wrap to address 0 forever instead of stopping in DONE.
module beat_address_sequencer
    import beat_seq_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter int                DATA_W    = 7,
    parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_DEFAULT),
    parameter int                TICK_DIV  = 50000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic [DATA_W-1:0] key_code,
    output logic [ADDR_W-1:0] addr_out,
    output logic              wr_pulse,
    output logic              rd_pulse,
    output logic [ADDR_W:0]   rec_len,
    output logic              full,
    output logic              empty,
    output logic              done,
    output logic [ADDR_W-1:0] visual_out
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              wr_q,      wr_d;
    logic              rd_q,      rd_d;
    logic [ADDR_W:0]   ptr_q,     ptr_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              full_q,    full_d;
    logic [DATA_W-1:0] prev_q,    prev_d;
    logic              first_q,   first_d;

    logic rec_start;
    logic play_start;
    logic code_change;
    logic do_write;
    logic do_read;
    logic last_entry;
    logic tick_en;
    logic tick;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rec_en) begin
                    state_d = S_REC;
                end else if (play_en && (rec_len_q != '0)) begin
                    state_d = S_PLAY;
                end
            end
            S_REC: begin
                if (!rec_en) begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (!play_en) begin
                    state_d = S_IDLE;
`ifndef BEAT_SEQ_LOOP_EN
                end else if (do_read && last_entry) begin
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                if (!play_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/control decode; the first read is issued without waiting for a tick
    always_comb begin
        rec_start   = (state_q == S_IDLE) && rec_en;
        play_start  = (state_q == S_IDLE) && !rec_en && play_en && (rec_len_q != '0);
        code_change = (key_code != prev_q);
        do_write    = (state_q == S_REC) && rec_en && code_change && !full_q;
        do_read     = (state_q == S_PLAY) && play_en && (first_q || tick);
        last_entry  = (ptr_q == rec_len_q - 1'b1);
        tick_en     = (state_q == S_PLAY) && play_en && !first_q;
`ifdef BEAT_SEQ_LOOP_EN
        done        = 1'b0;
`else
        done        = (state_q == S_DONE);
`endif
    end

    beat_tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .resetn(resetn),
        .clear (play_start),
        .enable(tick_en),
        .tick  (tick)
    );

    always_comb begin
        addr_d    = addr_q;
        wr_d      = do_write;
        rd_d      = do_read;
        ptr_d     = ptr_q;
        rec_len_d = rec_len_q;
        full_d    = full_q;
        prev_d    = prev_q;
        first_d   = first_q;

        if (rec_start) begin
            ptr_d     = '0;
            rec_len_d = '0;
            prev_d    = IDLE_CODE;
            full_d    = 1'b0;
        end

        // prev_code keeps tracking the keyboard even once the buffer is full
        if ((state_q == S_REC) && rec_en && code_change) begin
            prev_d = key_code;
        end

        if (do_write) begin
            addr_d    = ptr_q[ADDR_W-1:0];
            ptr_d     = ptr_q + 1'b1;
            rec_len_d = ptr_q + 1'b1;
            full_d    = ((ptr_q + 1'b1) == DEPTH_L);
        end

        if (play_start) begin
            ptr_d   = '0;
            first_d = 1'b1;
        end

        if (do_read) begin
            addr_d  = ptr_q[ADDR_W-1:0];
            first_d = 1'b0;
`ifdef BEAT_SEQ_LOOP_EN
            ptr_d   = last_entry ? '0 : ptr_q + 1'b1;
`else
            ptr_d   = ptr_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            ptr_q     <= '0;
            rec_len_q <= '0;
            full_q    <= 1'b0;
            prev_q    <= IDLE_CODE;
            first_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            ptr_q     <= ptr_d;
            rec_len_q <= rec_len_d;
            full_q    <= full_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
        end
    end

    assign addr_out   = addr_q;
    assign visual_out = addr_q;
    assign wr_pulse   = wr_q;
    assign rd_pulse   = rd_q;
    assign rec_len    = rec_len_q;
    assign full       = full_q;
    assign empty      = (rec_len_q == '0);

endmodule

// File: tb/tb_beat_address_sequencer.sv
// Directed bench for beat_address_sequencer with TICK_DIV = 4 and DEPTH = 4.
module tb_beat_address_sequencer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 7;

    logic              clk = 1'b0;
    logic              resetn;
    logic              rec_en;
    logic              play_en;
    logic [DATA_W-1:0] key_code;
    logic [ADDR_W-1:0] addr_out;
    logic              wr_pulse;
    logic              rd_pulse;
    logic [ADDR_W:0]   rec_len;
    logic              full;
    logic              empty;
    logic              done;
    logic [ADDR_W-1:0] visual_out;

    int vectors = 0;
    int errors  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;

    always #5 clk = ~clk;

    beat_address_sequencer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (4),
        .DATA_W   (DATA_W),
        .IDLE_CODE(7'd32),
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rec_en    (rec_en),
        .play_en   (play_en),
        .key_code  (key_code),
        .addr_out  (addr_out),
        .wr_pulse  (wr_pulse),
        .rd_pulse  (rd_pulse),
        .rec_len   (rec_len),
        .full      (full),
        .empty     (empty),
        .done      (done),
        .visual_out(visual_out)
    );

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) wr_cnt <= wr_cnt + 1;
        if (rd_pulse === 1'b1) rd_cnt <= rd_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Three quiet cycles then one read strobe at the expected address
    task automatic read_gap(input logic [ADDR_W-1:0] exp_addr);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_rd", rd_pulse, 0);
        end
        step();
        chk("step_rd", rd_pulse, 1);
        chk("step_addr", addr_out, exp_addr);
        chk("step_wr", wr_pulse, 0);
    endtask

    initial begin
        resetn = 1'b0; rec_en = 1'b1; play_en = 1'b0; key_code = 7'd32;
        #1;
        step(); step();
        chk("rst_addr", addr_out, 0);
        chk("rst_wr", wr_pulse, 0);
        chk("rst_rd", rd_pulse, 0);
        chk("rst_len", rec_len, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_done", done, 0);
        chk("rst_visual", visual_out, 0);
        resetn = 1'b1; rec_en = 1'b0;
        step();

        // Empty buffer: play request must be ignored
        play_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_rd", rd_pulse, 0);
            chk("empty_done", done, 0);
        end
        play_en = 1'b0;
        step();

        // Record 32 -> 65 -> 65 -> 66 -> 32
        rec_en = 1'b1; key_code = 7'd32;
        step();
        chk("rec_idle_code_wr", wr_pulse, 0);
        key_code = 7'd65; step();
        chk("rec0_wr", wr_pulse, 1);
        chk("rec0_addr", addr_out, 0);
        chk("rec0_len", rec_len, 1);
        step();
        chk("rec_repeat_wr", wr_pulse, 0);
        chk("rec_repeat_addr", addr_out, 0);
        key_code = 7'd66; step();
        chk("rec1_wr", wr_pulse, 1);
        chk("rec1_addr", addr_out, 1);
        key_code = 7'd32; step();
        chk("rec2_wr", wr_pulse, 1);
        chk("rec2_addr", addr_out, 2);
        step();
        chk("rec_hold_wr", wr_pulse, 0);
        chk("rec_len3", rec_len, 3);
        chk("rec_full", full, 0);
        chk("rec_empty", empty, 0);
        rec_en = 1'b0;
        step();

        // Playback of three entries
        play_en = 1'b1;
        step();
        chk("play_entry_rd", rd_pulse, 0);
        step();
        chk("play0_rd", rd_pulse, 1);
        chk("play0_addr", addr_out, 0);
        chk("play0_done", done, 0);
        read_gap(1);
        read_gap(2);
`ifdef BEAT_SEQ_LOOP_EN
        read_gap(0);
        read_gap(1);
        chk("loop_done", done, 0);
`else
        chk("play_done", done, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("done_rd", rd_pulse, 0);
            chk("done_addr", addr_out, 2);
            chk("done_hold", done, 1);
        end
`endif
        play_en = 1'b0;
        step();
        chk("play_exit_done", done, 0);
        chk("play_exit_rd", rd_pulse, 0);

        // Both requests high: record wins; five changes against DEPTH = 4
        rec_en = 1'b1; play_en = 1'b1;
        step();
        chk("prio_len", rec_len, 0);
        chk("prio_empty", empty, 1);
        chk("prio_rd", rd_pulse, 0);
        key_code = 7'd65; step();
        chk("full0_wr", wr_pulse, 1);
        chk("full0_rd", rd_pulse, 0);
        chk("full0_addr", addr_out, 0);
        key_code = 7'd66; step();
        chk("full1_addr", addr_out, 1);
        key_code = 7'd67; step();
        chk("full2_addr", addr_out, 2);
        chk("full2_full", full, 0);
        key_code = 7'd68; step();
        chk("full3_wr", wr_pulse, 1);
        chk("full3_addr", addr_out, 3);
        chk("full3_full", full, 1);
        chk("full3_len", rec_len, 4);
        key_code = 7'd69; step();
        chk("full4_wr", wr_pulse, 0);
        chk("full4_addr", addr_out, 3);
        chk("full4_len", rec_len, 4);
        chk("full4_full", full, 1);
        rec_en = 1'b0; play_en = 1'b0;
        step();

        // Reset between ticks during playback
        play_en = 1'b1;
        step();
        step();
        chk("rp0_rd", rd_pulse, 1);
        chk("rp0_addr", addr_out, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rp_gap_rd", rd_pulse, 0);
        end
        resetn = 1'b0;
        step();
        chk("rp_rd", rd_pulse, 0);
        chk("rp_addr", addr_out, 0);
        chk("rp_len", rec_len, 0);
        chk("rp_empty", empty, 1);
        chk("rp_full", full, 0);
        resetn = 1'b1; play_en = 1'b0;
        step(); step(); step();

        chk("total_wr", wr_cnt, 7);
`ifdef BEAT_SEQ_LOOP_EN
        chk("total_rd", rd_cnt, 6);
`else
        chk("total_rd", rd_cnt, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
